// File: rtl/tb_wait_event_pkg.sv
// Shared types for the multi-channel wait-event engine: command modes, completion status, FSM states.
package tb_wait_event_pkg;

    typedef enum logic [1:0] {
        MODE_RISE       = 2'd0,
        MODE_FALL       = 2'd1,
        MODE_ANY_CHANGE = 2'd2,
        MODE_LEVEL_EQ   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'd0,
        STAT_TIMEOUT = 2'd1,
        STAT_ABORT   = 2'd2,
        STAT_BAD_SEL = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/wait_cond_eval.sv
// Channel mux, previous-sample register and condition logic; hit is combinational on the current sample.
// No backpressure: prev loads while the parent arms and follows the channel every cycle of the wait.
module wait_cond_eval
    import tb_wait_event_pkg::*;
#(
    parameter int G_CH_NB = 5,
    parameter int G_WIDTH = 32,
    parameter int G_SEL_W = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [G_CH_NB-1:0][G_WIDTH-1:0] wait_bus,
    input  logic [G_SEL_W-1:0]              sel,
    input  mode_e                           mode,
    input  logic [G_WIDTH-1:0]              mask,
    input  logic [G_WIDTH-1:0]              value,
    input  logic                            load,
    input  logic                            upd,
    output logic                            hit
);

    logic [G_WIDTH-1:0] cur;
    logic [G_WIDTH-1:0] prev;

    // An out-of-range select reads as zero; the parent never arms on one.
    always_comb begin
        cur = '0;
        for (int i = 0; i < G_CH_NB; i++) begin
            if (sel == G_SEL_W'(i)) cur = wait_bus[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
        end else if (load || upd) begin
            prev <= cur;
        end
    end

    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_RISE:       hit = !prev[0] && cur[0];
            MODE_FALL:       hit = prev[0] && !cur[0];
            MODE_ANY_CHANGE: hit = |((prev ^ cur) & mask);
            MODE_LEVEL_EQ:   hit = ((cur & mask) == (value & mask));
            default:         hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/tb_wait_event_mc.sv
// Commanded wait-event engine: accept to done in >=3 cycles (BAD_SEL in 1), one-cycle done pulse.
// o_cmd_ready is high only in IDLE, so a command offered while busy is held by the master.
module tb_wait_event_mc
    import tb_wait_event_pkg::*;
#(
    parameter int G_CH_NB = 5,
    parameter int G_WIDTH = 32,
    parameter int G_TMO_W = 32,
    parameter int G_SEL_W = (G_CH_NB > 1) ? $clog2(G_CH_NB) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [G_CH_NB-1:0][G_WIDTH-1:0] i_wait,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic [G_SEL_W-1:0]              i_cmd_sel,
    input  logic [1:0]                      i_cmd_mode,
    input  logic [G_WIDTH-1:0]              i_cmd_mask,
    input  logic [G_WIDTH-1:0]              i_cmd_value,
    input  logic [G_TMO_W-1:0]              i_cmd_timeout,
    input  logic                            i_abort,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [1:0]                      o_status,
    output logic [G_TMO_W-1:0]              o_elapsed
);

    localparam logic [G_SEL_W:0] CH_NB = (G_SEL_W + 1)'(G_CH_NB);

    state_e               state, state_nx;
    logic [G_SEL_W-1:0]   sel_q;
    mode_e                mode_q;
    logic [G_WIDTH-1:0]   mask_q, value_q;
    logic [G_TMO_W-1:0]   tmo_q, cnt;
    logic [G_TMO_W:0]     cnt_inc;
    status_e              status_q, fin_status;
    logic [G_TMO_W-1:0]   elapsed_q, fin_elapsed;
    logic                 accept, bad_sel, fin, hit;

    assign o_cmd_ready = (state == S_IDLE) && !rst;
    assign accept      = i_cmd_valid && o_cmd_ready;
    assign bad_sel     = ({1'b0, i_cmd_sel} >= CH_NB);
    assign cnt_inc     = {1'b0, cnt} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Priority in WAIT: abort, then hit, then timeout, so a hit on the timeout cycle reports OK.
    always_comb begin
        state_nx    = state;
        fin         = 1'b0;
        fin_status  = STAT_OK;
        fin_elapsed = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bad_sel) begin
                        state_nx    = S_DONE;
                        fin         = 1'b1;
                        fin_status  = STAT_BAD_SEL;
                        fin_elapsed = '0;
                    end else begin
                        state_nx = S_ARM;
                    end
                end
            end
            S_ARM: begin
                if (i_abort) begin
                    state_nx   = S_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_ABORT;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    state_nx   = S_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_ABORT;
                end else if (hit) begin
                    state_nx   = S_DONE;
                    fin        = 1'b1;
                    fin_status = STAT_OK;
                end else if ((tmo_q != '0) && (cnt_inc == {1'b0, tmo_q})) begin
                    state_nx    = S_DONE;
                    fin         = 1'b1;
                    fin_status  = STAT_TIMEOUT;
                    fin_elapsed = tmo_q;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            mode_q    <= MODE_RISE;
            mask_q    <= '0;
            value_q   <= '0;
            tmo_q     <= '0;
            cnt       <= '0;
            status_q  <= STAT_OK;
            elapsed_q <= '0;
        end else begin
            if (accept) begin
                sel_q   <= i_cmd_sel;
                mode_q  <= mode_e'(i_cmd_mode);
                mask_q  <= i_cmd_mask;
                value_q <= i_cmd_value;
                tmo_q   <= i_cmd_timeout;
            end
            if (state == S_ARM) begin
                cnt <= '0;
            end else if (state == S_WAIT && state_nx == S_WAIT && !(&cnt)) begin
                cnt <= cnt_inc[G_TMO_W-1:0];
            end
            if (fin) begin
                status_q  <= fin_status;
                elapsed_q <= fin_elapsed;
            end
        end
    end

    wait_cond_eval #(
        .G_CH_NB (G_CH_NB),
        .G_WIDTH (G_WIDTH),
        .G_SEL_W (G_SEL_W)
    ) u_eval (
        .clk      (clk),
        .rst      (rst),
        .wait_bus (i_wait),
        .sel      (sel_q),
        .mode     (mode_q),
        .mask     (mask_q),
        .value    (value_q),
        .load     (state == S_ARM),
        .upd      (state == S_WAIT),
        .hit      (hit)
    );

    assign o_busy    = (state == S_ARM) || (state == S_WAIT);
    assign o_done    = (state == S_DONE);
    assign o_status  = status_q;
    assign o_elapsed = elapsed_q;

endmodule

// File: tb/tb_tb_wait_event_mc.sv
// Directed vector table plus hand-written abort, backpressure and reset sequences for tb_wait_event_mc.
module tb_tb_wait_event_mc;

    localparam int CH = 5;
    localparam int W  = 32;
    localparam int TW = 32;
    localparam int SW = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [CH-1:0][W-1:0]   wait_bus;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [SW-1:0]          cmd_sel;
    logic [1:0]             cmd_mode;
    logic [W-1:0]           cmd_mask;
    logic [W-1:0]           cmd_value;
    logic [TW-1:0]          cmd_timeout;
    logic                   abort;
    logic                   busy;
    logic                   done;
    logic [1:0]             status;
    logic [TW-1:0]          elapsed;

    always #5 clk = ~clk;

    tb_wait_event_mc #(
        .G_CH_NB (CH),
        .G_WIDTH (W),
        .G_TMO_W (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_wait        (wait_bus),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_sel     (cmd_sel),
        .i_cmd_mode    (cmd_mode),
        .i_cmd_mask    (cmd_mask),
        .i_cmd_value   (cmd_value),
        .i_cmd_timeout (cmd_timeout),
        .i_abort       (abort),
        .o_busy        (busy),
        .o_done        (done),
        .o_status      (status),
        .o_elapsed     (elapsed)
    );

    typedef struct {
        logic [SW-1:0] sel;
        logic [1:0]    mode;
        logic [W-1:0]  mask;
        logic [W-1:0]  value;
        logic [TW-1:0] tmo;
        logic [W-1:0]  w0;      // channel value while arming
        logic [W-1:0]  w1;      // channel value from WAIT cycle chg_at on
        int            chg_at;
        logic [1:0]    exp_st;
        logic [TW-1:0] exp_el;
        int            exp_lat; // cycles from the accepting edge to the done sample, accept edge = 1
    } vec_t;

    vec_t vt[11];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [SW-1:0] s, input logic [1:0] m, input logic [W-1:0] mk,
                         input logic [W-1:0] v, input logic [TW-1:0] t);
        cmd_sel = s; cmd_mode = m; cmd_mask = mk; cmd_value = v; cmd_timeout = t;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int idx;
        logic busy_seen;
        logic done_seen;
        vec_t v;

        //        sel   mode  mask          value         tmo    w0            w1            chg  st  el  lat
        vt[0]  = '{3'd2, 2'd0, 32'h0,        32'h0,        32'd0, 32'h0,        32'h1,        10,  2'd0, 32'd10, 13};
        vt[1]  = '{3'd0, 2'd3, 32'hFFFF0000, 32'hCAFE1234, 32'd0, 32'hCAFEDECA, 32'hCAFEDECA, 255, 2'd0, 32'd0,  3};
        vt[2]  = '{3'd1, 2'd2, 32'h000000FF, 32'h0,        32'd20,32'h0,        32'h100,      0,   2'd1, 32'd20, 22};
        vt[3]  = '{3'd3, 2'd1, 32'h0,        32'h0,        32'd0, 32'h1,        32'h0,        5,   2'd0, 32'd5,  8};
        vt[4]  = '{3'd4, 2'd2, 32'h000000FF, 32'h0,        32'd0, 32'h12,       32'h13,       4,   2'd0, 32'd4,  7};
        vt[5]  = '{3'd2, 2'd0, 32'h0,        32'h0,        32'd3, 32'h0,        32'h1,        2,   2'd0, 32'd2,  5};
        vt[6]  = '{3'd2, 2'd0, 32'h0,        32'h0,        32'd3, 32'h0,        32'h1,        3,   2'd1, 32'd3,  5};
        vt[7]  = '{3'd0, 2'd3, 32'hFFFFFFFF, 32'h1,        32'd1, 32'h0,        32'h0,        255, 2'd1, 32'd1,  3};
        vt[8]  = '{3'd7, 2'd0, 32'h0,        32'h0,        32'd0, 32'h0,        32'h0,        255, 2'd3, 32'd0,  1};
        vt[9]  = '{3'd5, 2'd3, 32'h0,        32'h0,        32'd0, 32'h0,        32'h0,        255, 2'd3, 32'd0,  1};
        vt[10] = '{3'd1, 2'd0, 32'h0,        32'h0,        32'd4, 32'h0,        32'h2,        1,   2'd1, 32'd4,  6};

        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; wait_bus = '0;
        cmd_sel = '0; cmd_mode = '0; cmd_mask = '0; cmd_value = '0; cmd_timeout = '0;
        tick();
        tick();
        check("rst ready low", cmd_ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst status", status, 2'd0);
        check("rst elapsed", elapsed, 32'd0);
        rst = 1'b0;
        #1;
        check("ready after rst", cmd_ready, 1'b1);

        for (int i = 0; i < 11; i++) begin
            v = vt[i];
            idx = int'(v.sel);
            wait_bus = '0;
            if (idx < CH) wait_bus[idx] = v.w0;
            busy_seen = 1'b0;
            issue(v.sel, v.mode, v.mask, v.value, v.tmo);
            lat = 1;
            while (!done && lat < 60) begin
                if (busy) busy_seen = 1'b1;
                tick();
                lat++;
                if (lat == v.chg_at + 2 && idx < CH) wait_bus[idx] = v.w1;
            end
            check($sformatf("v%0d done", i), done, 1'b1);
            check($sformatf("v%0d status", i), status, v.exp_st);
            check($sformatf("v%0d elapsed", i), elapsed, v.exp_el);
            check($sformatf("v%0d latency", i), lat, v.exp_lat);
            check($sformatf("v%0d busy", i), busy_seen, (idx < CH));
            tick();
            check($sformatf("v%0d ready after", i), cmd_ready, 1'b1);
        end

        // FALL armed, abort raised on the same cycle as the falling edge
        wait_bus = '0; wait_bus[3] = 32'h1;
        issue(3'd3, 2'd1, 32'h0, 32'h0, 32'd0);
        tick(); tick(); tick();
        wait_bus[3] = 32'h0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort done", done, 1'b1);
        check("abort status", status, 2'd2);
        check("abort elapsed", elapsed, 32'd2);
        tick();
        check("abort done clears", done, 1'b0);
        check("status held", status, 2'd2);
        check("elapsed held", elapsed, 32'd2);

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle abort ready", cmd_ready, 1'b1);
        check("idle abort no done", done, 1'b0);

        // A second command offered while busy waits for IDLE
        wait_bus = '0;
        issue(3'd1, 2'd0, 32'h0, 32'h0, 32'd5);
        cmd_sel = 3'd6; cmd_valid = 1'b1;
        check("not ready when busy", cmd_ready, 1'b0);
        wait_done(lat);
        check("held cmd first status", status, 2'd1);
        check("held cmd first elapsed", elapsed, 32'd5);
        check("held cmd first latency", lat, 7);
        tick();
        tick();
        cmd_valid = 1'b0;
        check("held cmd second done", done, 1'b1);
        check("held cmd second status", status, 2'd3);
        tick();

        // Reset in the middle of a wait discards the command
        wait_bus = '0;
        issue(3'd4, 2'd0, 32'h0, 32'h0, 32'd0);
        tick(); tick(); tick();
        rst = 1'b1;
        wait_bus[4] = 32'h1;
        tick();
        check("midrst busy", busy, 1'b0);
        check("midrst ready", cmd_ready, 1'b0);
        check("midrst status", status, 2'd0);
        check("midrst elapsed", elapsed, 32'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (done) done_seen = 1'b1;
            tick();
        end
        check("midrst no done", done_seen, 1'b0);
        check("midrst ready after", cmd_ready, 1'b1);
        issue(3'd4, 2'd3, 32'hFFFFFFFF, 32'h1, 32'd0);
        wait_done(lat);
        check("post rst status", status, 2'd0);
        check("post rst elapsed", elapsed, 32'd0);
        check("post rst latency", lat, 3);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
